// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - display code encoding shared by the display manager and the scan driver
package display_pkg;

  localparam logic [5:0] DISP_BLANK_CODE = 6'b100000;

  localparam logic [4:0] GLY_0    = 5'd0;
  localparam logic [4:0] GLY_1    = 5'd1;
  localparam logic [4:0] GLY_2    = 5'd2;
  localparam logic [4:0] GLY_3    = 5'd3;
  localparam logic [4:0] GLY_4    = 5'd4;
  localparam logic [4:0] GLY_5    = 5'd5;
  localparam logic [4:0] GLY_6    = 5'd6;
  localparam logic [4:0] GLY_7    = 5'd7;
  localparam logic [4:0] GLY_8    = 5'd8;
  localparam logic [4:0] GLY_9    = 5'd9;
  localparam logic [4:0] GLY_A    = 5'd10;
  localparam logic [4:0] GLY_J    = 5'd11;
  localparam logic [4:0] GLY_U    = 5'd12;
  localparam logic [4:0] GLY_P    = 5'd13;
  localparam logic [4:0] GLY_E    = 5'd14;
  localparam logic [4:0] GLY_DASH = 5'd15;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_A    = 7'h08;
  localparam logic [6:0] SEG_J    = 7'h61;
  localparam logic [6:0] SEG_U    = 7'h41;
  localparam logic [6:0] SEG_P    = 7'h0C;
  localparam logic [6:0] SEG_E    = 7'h06;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [7:0] AN_OFF = 8'hFF;

  // Digit 0 (leftmost) drives an[7]
  function automatic logic [7:0] anode_mask(input logic [2:0] idx);
    return ~(8'h80 >> idx);
  endfunction

endpackage

// File: rtl/display_seg_decoder.sv
// rtl/display_seg_decoder.sv - combinational 5-bit glyph to active-low 7-segment pattern
module display_seg_decoder
  import display_pkg::*;
(
  input  logic [4:0] i_glyph,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_glyph)
      GLY_0:    o_seg = SEG_0;
      GLY_1:    o_seg = SEG_1;
      GLY_2:    o_seg = SEG_2;
      GLY_3:    o_seg = SEG_3;
      GLY_4:    o_seg = SEG_4;
      GLY_5:    o_seg = SEG_5;
      GLY_6:    o_seg = SEG_6;
      GLY_7:    o_seg = SEG_7;
      GLY_8:    o_seg = SEG_8;
      GLY_9:    o_seg = SEG_9;
      GLY_A:    o_seg = SEG_A;
      GLY_J:    o_seg = SEG_J;
      GLY_U:    o_seg = SEG_U;
      GLY_P:    o_seg = SEG_P;
      GLY_E:    o_seg = SEG_E;
      GLY_DASH: o_seg = SEG_DASH;
      default:  o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - frame-latched 8-digit 7-segment multiplexer with inter-digit blanking
module display_scan_driver
  import display_pkg::*;
#(
  parameter int CLKS_PER_DIGIT = 50000,
  parameter int BLANK_CLKS     = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int PW = (CLKS_PER_DIGIT > 2) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(CLKS_PER_DIGIT - 1);
  localparam logic [PW-1:0] PH_BLANK = PW'(BLANK_CLKS);

  logic [PW-1:0] r_phase_cnt;
  logic [2:0]    r_idx;
  logic [5:0]    r_shadow [0:7];
  logic [5:0]    w_d      [0:7];
  logic [5:0]    w_code;
  logic [6:0]    w_seg;
  logic          w_snap;

  assign w_d[0] = d1;
  assign w_d[1] = d2;
  assign w_d[2] = d3;
  assign w_d[3] = d4;
  assign w_d[4] = d5;
  assign w_d[5] = d6;
  assign w_d[6] = d7;
  assign w_d[7] = d8;

  assign w_code = r_shadow[r_idx];
  assign w_snap = (r_phase_cnt == '0) && (r_idx == 3'd0);
  assign dp     = 1'b1;

  display_seg_decoder u_dec (
    .i_glyph (w_code[4:0]),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase_cnt <= '0;
      r_idx       <= 3'd0;
      for (int i = 0; i < 8; i++) r_shadow[i] <= DISP_BLANK_CODE;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      frame_tick  <= 1'b0;
    end else begin
      if (r_phase_cnt == PH_LAST) begin
        r_phase_cnt <= '0;
        r_idx       <= r_idx + 3'd1;
      end else begin
        r_phase_cnt <= r_phase_cnt + 1'b1;
      end

      // The whole frame is captured at once so digits never mix two manager states
      frame_tick <= w_snap;
      if (w_snap) begin
        for (int i = 0; i < 8; i++) r_shadow[i] <= w_d[i];
      end

      // Slot 0 is always in its blank phase at the snapshot edge, so reading the old shadow is harmless
      if (r_phase_cnt < PH_BLANK || w_code[5]) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end else begin
        an  <= anode_mask(r_idx);
        seg <= w_seg;
      end
    end
  end

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Consumer side of the eight 6-bit display codes d1..d8 that the game's display manager produces each state.
- Latches one coherent frame of codes and time-multiplexes the eight 7-segment digits on the board.
- Decodes each code to active-low segment and anode patterns, with a blanking gap between digits to suppress ghosting.
- Sits between the display manager and the FPGA pins.

Parameters:
CLKS_PER_DIGIT, 50000, clock cycles each digit slot lasts (>=2)
BLANK_CLKS, 500, cycles at the start of each slot with all anodes off (1..CLKS_PER_DIGIT-1)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
d1..d8  input  6 each  display codes: bit5=blank (1 = digit off), bits[4:0]=glyph code; d1 is the leftmost digit
an  output  8  anode enables, active-low; an[7]=d1 ... an[0]=d8
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low, constant 1 (off) in this revision
frame_tick  output  1  one-cycle pulse per frame snapshot

Behaviour:
- Reset (reset=0, asynchronous):
  - phase_cnt=0, idx=0.
  - Shadow registers all 6'b100000.
  - an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
- Counters:
  - phase_cnt counts 0..CLKS_PER_DIGIT-1 and wraps to 0.
  - idx increments (0..7, wrap 7->0) on each phase_cnt wrap.
- All outputs are registered.
  - Values presented after a clock edge are computed from the (phase_cnt, idx) held before that edge.
  - Output latency is therefore 1 cycle.
- Snapshot:
  - On any edge where phase_cnt==0 and idx==0, shadow[0..7] <= d1..d8 and frame_tick <= 1.
  - frame_tick <= 0 on every other edge.
  - The first snapshot occurs on the first edge after reset is released.
  - Inputs are ignored between snapshots, so no tearing.
- Blank phase (phase_cnt < BLANK_CLKS): an <= 8'hFF, seg <= 7'h7F.
- On phase (phase_cnt >= BLANK_CLKS):
  - If shadow[idx] bit5=1: an <= 8'hFF, seg <= 7'h7F.
  - Else: an <= all ones except bit (7-idx)=0; seg <= decode(shadow[idx][4:0]).
- Glyph decode (seg values, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - 10 "A"=08, 11 "J"=61, 12 "U"=41, 13 "P"=0C, 14 "E"=06, 15 "-"=3F
  - 16..31 = 7F (lit anode, no segments)
- Timing: frame period = 8*CLKS_PER_DIGIT cycles; exactly one frame_tick per frame.
- Reset mid-scan:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - The scan restarts at digit 0 with a fresh snapshot on the first edge after release.
- Input changes coincident with the snapshot edge are captured; input changes on any other edge wait for the next frame.

Decomposition:
- Package display_pkg:
  - DISP_BLANK_CODE = 6'b100000
  - glyph code constants GLY_0..GLY_9, GLY_A, GLY_J, GLY_U, GLY_P, GLY_E, GLY_DASH
  - SEG_OFF = 7'h7F
  - segment pattern constants
  - Shared with the display manager so both ends agree on the encoding.
- Sub-module display_seg_decoder: purely combinational, 5-bit glyph -> 7-bit active-low seg.
- Counters, shadow registers and output registers stay in display_scan_driver.

Test Plan:
- All tests use CLKS_PER_DIGIT=4, BLANK_CLKS=1.
- Reset held low with random d inputs -> an=FF, seg=7F, dp=1, frame_tick=0. Assert reset low asynchronously mid-cycle -> outputs reach these values before the next edge.
- Release reset; d1=6'b000001, d2..d8=6'b100000:
  - After edge 1: frame_tick=1, an=FF.
  - After edges 2-4: an=7F, seg=79.
  - After edge 5: an=FF.
  - frame_tick recurs every 32 cycles.
- Set d3=6'b100011 and d4=6'b001011 -> during the idx 2 slot an stays FF; during the idx 3 "on" cycles an=EF, seg=61.
- Change d1 from 6'b000001 to 6'b001110 during idx 4 -> seg during the idx 0 slot stays 79 until after the next frame_tick, then 06.
- Assert reset low during idx 5 on-phase -> an=FF at once. After release, the first frame_tick comes on the first edge and the scan resumes at idx 0.
- Set d8=6'b010101 (glyph 21) -> an=FE with seg=7F during the idx 7 on-phase; the blank phase keeps an=FF.
